median_rank: RTL

- Parametrised successor to the fixed 9-tap median block in the video filtering path.
- Collects a window of P unsigned W-bit samples, sorts them with an odd-even transposition network, and outputs the sample at a selectable rank (min, median, max or any rank).
- Sits between the pixel/line buffer and the downstream stage, using the same DI/DSI to DO/DSO stream convention as the existing filters.

---
 rtl/median_rank.sv | 117 +++++++++++
 1 files changed

// File: rtl/median_rank.sv
// Rank-select filter: sorts a P-sample window (odd-even transposition) and emits the chosen rank; MEDIAN_RANK_EN adds a runtime RANK port.
// DSO rises P+1 edges after the P-th sample; READY drops for SORT+OUT and samples offered then are dropped.
module median_rank #(
    parameter int W  = 8,
    parameter int P  = 9,
    parameter int RW = $clog2(P)
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic [W-1:0]  DI,
    input  logic          DSI,
`ifdef MEDIAN_RANK_EN
    input  logic [RW-1:0] RANK,
`endif
    output logic          READY,
    output logic [W-1:0]  DO,
    output logic          DSO
);
    localparam int CW = $clog2(P + 1);

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, phase_q;
    logic [W-1:0]  win_q [P];
    logic [W-1:0]  net_d [P];
    logic [W-1:0]  do_q;
    logic          dso_q;
    logic [RW-1:0] rank_eff;
    logic          accept, load_last, sort_last;

    generate
        if (P < 3 || (P % 2) == 0) begin : g_bad_p
            $error("median_rank: P must be odd and >= 3");
        end
    endgenerate

    assign accept    = (state_q == LOAD) && DSI;
    assign load_last = accept && (cnt_q == CW'(P - 1));
    assign sort_last = (state_q == SORT) && (phase_q == CW'(P - 1));
    assign READY     = (state_q == LOAD);
    assign DO        = do_q;
    assign DSO       = dso_q;

`ifdef MEDIAN_RANK_EN
    logic [RW-1:0] rank_q;

    // Rank belongs to the window, so only the first sample's RANK counts.
    always_ff @(posedge CLK) begin
        if (accept && cnt_q == '0)
            rank_q <= RANK;
    end

    assign rank_eff = (rank_q >= RW'(P)) ? RW'(P - 1) : rank_q;
`else
    assign rank_eff = RW'((P - 1) / 2);
`endif

    always_ff @(posedge CLK) begin
        if (!nRST)
            state_q <= LOAD;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (load_last) state_d = SORT;
            SORT:    if (sort_last) state_d = OUT;
            OUT:     state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // One network phase: pairs start at index 0 on even phases, 1 on odd.
    always_comb begin
        for (int i = 0; i < P; i++)
            net_d[i] = win_q[i];
        for (int i = 0; i < P - 1; i++) begin
            if ((i % 2) == int'(phase_q[0]) && win_q[i] > win_q[i+1]) begin
                net_d[i]   = win_q[i+1];
                net_d[i+1] = win_q[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt_q   <= '0;
            phase_q <= '0;
            do_q    <= '0;
            dso_q   <= 1'b0;
        end else begin
            dso_q <= 1'b0;
            unique case (state_q)
                LOAD: begin
                    if (accept) begin
                        win_q[cnt_q] <= DI;
                        cnt_q        <= load_last ? '0 : cnt_q + 1'b1;
                        phase_q      <= '0;
                    end
                end
                SORT: begin
                    for (int i = 0; i < P; i++)
                        win_q[i] <= net_d[i];
                    phase_q <= sort_last ? '0 : phase_q + 1'b1;
                end
                OUT: begin
                    do_q  <= win_q[rank_eff];
                    dso_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
